multicycle_control_unit: RTL and testbench

Sequenced control unit for the multicycle MIPS datapath. It latches the fetched instruction, decodes it, and steps through FETCH/DECODE/EXEC/MEM/WB states. Memory enables, register writes and PC writes are qualified per state and held across variable-latency `ihit`/`dhit` handshakes. It adds a sticky halt, a memory-wait watchdog with a fault state, an optional merged writeback, and a retired-instruction counter. It sits between the caches and the datapath, replacing the single-cycle decoder.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/multicycle_control_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the multicycle datapath and its control unit.
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_SLL,
      ALU_SRL,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU
   } aluop_t;

endpackage

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control: latches the IR, decodes it and sequences FETCH/DECODE/EXEC/MEM/WB,
// with sticky halt/fault states, a memory-wait watchdog and a retired-instruction counter.
module multicycle_control_unit
   import cpu_types_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned WB_STAGE    = 1,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   // ALU zero flag from the datapath; qualifies the branch-taken pcmode
   input  logic             zero,
   input  logic [31:0]      imemload,
   output logic [31:0]      instr,
   output logic             iREN,
   output logic             dREN,
   output logic             dWEN,
   output logic             regWEN,
   output logic             pcWEN,
   output logic [1:0]       RdOrRtOr31,
   output logic [1:0]       pcmode,
   output logic [1:0]       memOp,
   output logic             extType,
   output logic             immorRt,
   output aluop_t           alu_op,
   output logic             halt,
   output logic             fault,
   output logic [CNT_W-1:0] retired
);

   localparam logic [5:0] OpRtype = 6'h00, OpJ     = 6'h02, OpJal   = 6'h03, OpBeq  = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05, OpAddi  = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0A;
   localparam logic [5:0] OpSltiu = 6'h0B, OpAndi  = 6'h0C, OpOri   = 6'h0D, OpXori = 6'h0E;
   localparam logic [5:0] OpLui   = 6'h0F, OpLw    = 6'h23, OpSw    = 6'h2B, OpHalt = 6'h3F;

   localparam logic [5:0] FnSll = 6'h00, FnSrl  = 6'h02, FnJr  = 6'h08, FnAdd  = 6'h20;
   localparam logic [5:0] FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23, FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25, FnXor  = 6'h26, FnNor = 6'h27, FnSlt  = 6'h2A;
   localparam logic [5:0] FnSltu = 6'h2B;

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalted, StFault
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [31:0]      wait_q, wait_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [5:0] opcode, funct;
   logic       legal, is_flow, is_jal, is_load, is_store, is_halt, timeout;

   assign opcode  = ir_q[31:26];
   assign funct   = ir_q[5:0];
   assign instr   = ir_q;
   assign retired = retired_q;
   assign halt    = (state_q == StHalted);
   assign fault   = (state_q == StFault);
   assign timeout = (MEM_TIMEOUT != 0) && ((wait_q + 32'd1) == MEM_TIMEOUT);

   always_comb begin
      RdOrRtOr31 = 2'd1;
      pcmode     = 2'd0;
      memOp      = 2'd0;
      extType    = 1'b1;
      immorRt    = 1'b1;
      alu_op     = ALU_ADD;
      legal      = 1'b1;
      is_flow    = 1'b0;
      is_jal     = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_halt    = 1'b0;
      case (opcode)
         OpRtype: begin
            RdOrRtOr31 = 2'd0;
            immorRt    = 1'b0;
            case (funct)
               FnSll:          alu_op = ALU_SLL;
               FnSrl:          alu_op = ALU_SRL;
               FnAdd, FnAddu:  alu_op = ALU_ADD;
               FnSub, FnSubu:  alu_op = ALU_SUB;
               FnAnd:          alu_op = ALU_AND;
               FnOr:           alu_op = ALU_OR;
               FnXor:          alu_op = ALU_XOR;
               FnNor:          alu_op = ALU_NOR;
               FnSlt:          alu_op = ALU_SLT;
               FnSltu:         alu_op = ALU_SLTU;
               FnJr: begin
                  pcmode  = 2'd3;
                  is_flow = 1'b1;
               end
               default:        alu_op = ALU_ADD;
            endcase
         end
         OpJ: begin
            pcmode  = 2'd2;
            immorRt = 1'b0;
            is_flow = 1'b1;
         end
         OpJal: begin
            pcmode     = 2'd2;
            RdOrRtOr31 = 2'd2;
            memOp      = 2'd2;
            immorRt    = 1'b0;
            is_flow    = 1'b1;
            is_jal     = 1'b1;
         end
         OpBeq, OpBne: begin
            alu_op  = ALU_SUB;
            immorRt = 1'b0;
            is_flow = 1'b1;
            pcmode  = ((opcode == OpBeq) == zero) ? 2'd1 : 2'd0;
         end
         OpAddi, OpAddiu: alu_op = ALU_ADD;
         OpSlti:          alu_op = ALU_SLT;
         OpSltiu:         alu_op = ALU_SLTU;
         OpAndi: begin
            alu_op  = ALU_AND;
            extType = 1'b0;
         end
         OpOri: begin
            alu_op  = ALU_OR;
            extType = 1'b0;
         end
         OpXori: begin
            alu_op  = ALU_XOR;
            extType = 1'b0;
         end
         OpLui:           memOp = 2'd3;
         OpLw: begin
            memOp   = 2'd1;
            is_load = 1'b1;
         end
         OpSw:            is_store = 1'b1;
         OpHalt:          is_halt = 1'b1;
         default:         legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      wait_d  = '0;
      iREN    = 1'b0;
      dREN    = 1'b0;
      dWEN    = 1'b0;
      regWEN  = 1'b0;
      pcWEN   = 1'b0;
      unique case (state_q)
         StIdle:   state_d = StFetch;
         StFetch: begin
            iREN = 1'b1;
            if (ihit) begin
               ir_d    = imemload;
               state_d = StDecode;
            end else begin
               wait_d = wait_q + 32'd1;
               if (timeout) state_d = StFault;
            end
         end
         StDecode: begin
            if (is_halt)     state_d = StHalted;
            else if (!legal) state_d = StFault;
            else             state_d = StExec;
         end
         StExec: begin
            if (is_flow) begin
               pcWEN   = 1'b1;
               regWEN  = is_jal;
               state_d = StFetch;
            end else if (is_load || is_store) begin
               state_d = StMem;
            end else if (WB_STAGE != 0) begin
               state_d = StWb;
            end else begin
               regWEN  = 1'b1;
               pcWEN   = 1'b1;
               state_d = StFetch;
            end
         end
         StMem: begin
            dREN = is_load;
            dWEN = is_store;
            // Commit on dhit is combinational only for SW and for LW without a WB stage
            if (dhit) begin
               if (is_store) begin
                  pcWEN   = 1'b1;
                  state_d = StFetch;
               end else if (WB_STAGE != 0) begin
                  state_d = StWb;
               end else begin
                  regWEN  = 1'b1;
                  pcWEN   = 1'b1;
                  state_d = StFetch;
               end
            end else begin
               wait_d = wait_q + 32'd1;
               if (timeout) state_d = StFault;
            end
         end
         StWb: begin
            regWEN  = 1'b1;
            pcWEN   = 1'b1;
            state_d = StFetch;
         end
         StHalted: state_d = StHalted;
         StFault:  state_d = StFault;
      endcase
   end

   assign retired_d = retired_q + CNT_W'(pcWEN);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= StIdle;
         ir_q      <= '0;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: one instance with a WB stage, one without,
// both with a 4-cycle watchdog; commit records are scoreboarded against a latency model.
module tb_multicycle_control_unit;
   import cpu_types_pkg::*;

   localparam int KAlu = 0, KLw = 1, KSw = 2, KFlow = 3, KJal = 4;

   typedef struct {
      string      tag;
      int         lat;
      int         iren_n;
      int         mem_n;
      int         rw_n;
      int         rw_cyc;
      bit         chk_wb;
      logic [1:0] dst;
      logic [1:0] memop;
      logic [1:0] pcm;
      bit         chk_alu;
      aluop_t     alu;
      bit         chk_ext;
      logic       ext;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int unsigned ret_model = 0;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        sel = 1'b1;
   logic        ihit = 1'b0, dhit = 1'b0, zero = 1'b0;
   logic [31:0] imemload = '0;

   always #5 clk = ~clk;

   logic ihit_1, dhit_1, ihit_0, dhit_0;
   assign ihit_1 = ihit & sel;
   assign dhit_1 = dhit & sel;
   assign ihit_0 = ihit & ~sel;
   assign dhit_0 = dhit & ~sel;

   logic [31:0] instr_1, instr_0, instr_o, ret_1, ret_0, ret_o;
   logic        iren_1, iren_0, iren_o, dren_1, dren_0, dren_o, dwen_1, dwen_0, dwen_o;
   logic        regwen_1, regwen_0, regwen_o, pcwen_1, pcwen_0, pcwen_o;
   logic [1:0]  dst_1, dst_0, dst_o, pcm_1, pcm_0, pcm_o, memop_1, memop_0, memop_o;
   logic        ext_1, ext_0, ext_o, imm_1, imm_0, imm_o;
   logic        halt_1, halt_0, halt_o, fault_1, fault_0, fault_o;
   aluop_t      alu_1, alu_0, alu_o;

   assign instr_o  = sel ? instr_1  : instr_0;
   assign ret_o    = sel ? ret_1    : ret_0;
   assign iren_o   = sel ? iren_1   : iren_0;
   assign dren_o   = sel ? dren_1   : dren_0;
   assign dwen_o   = sel ? dwen_1   : dwen_0;
   assign regwen_o = sel ? regwen_1 : regwen_0;
   assign pcwen_o  = sel ? pcwen_1  : pcwen_0;
   assign dst_o    = sel ? dst_1    : dst_0;
   assign pcm_o    = sel ? pcm_1    : pcm_0;
   assign memop_o  = sel ? memop_1  : memop_0;
   assign ext_o    = sel ? ext_1    : ext_0;
   assign imm_o    = sel ? imm_1    : imm_0;
   assign halt_o   = sel ? halt_1   : halt_0;
   assign fault_o  = sel ? fault_1  : fault_0;
   assign alu_o    = sel ? alu_1    : alu_0;

   multicycle_control_unit #(.MEM_TIMEOUT(4), .WB_STAGE(1), .CNT_W(32)) dut_wb1 (
      .CLK(clk), .nRST(nrst), .ihit(ihit_1), .dhit(dhit_1), .zero(zero), .imemload(imemload),
      .instr(instr_1), .iREN(iren_1), .dREN(dren_1), .dWEN(dwen_1), .regWEN(regwen_1),
      .pcWEN(pcwen_1), .RdOrRtOr31(dst_1), .pcmode(pcm_1), .memOp(memop_1), .extType(ext_1),
      .immorRt(imm_1), .alu_op(alu_1), .halt(halt_1), .fault(fault_1), .retired(ret_1)
   );

   multicycle_control_unit #(.MEM_TIMEOUT(4), .WB_STAGE(0), .CNT_W(32)) dut_wb0 (
      .CLK(clk), .nRST(nrst), .ihit(ihit_0), .dhit(dhit_0), .zero(zero), .imemload(imemload),
      .instr(instr_0), .iREN(iren_0), .dREN(dren_0), .dWEN(dwen_0), .regWEN(regwen_0),
      .pcWEN(pcwen_0), .RdOrRtOr31(dst_0), .pcmode(pcm_0), .memOp(memop_0), .extType(ext_0),
      .immorRt(imm_0), .alu_op(alu_0), .halt(halt_0), .fault(fault_0), .retired(ret_0)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected commit record for one instruction, from the latency rules
   task automatic push_exp(input string tag, input int kind, input int iw, input int dw,
                           input logic [1:0] dst, input logic [1:0] mo, input logic [1:0] pm,
                           input bit chk_alu, input aluop_t alu, input bit chk_ext,
                           input logic ext);
      exp_t e;
      bit   wb = (sel == 1'b1);
      e.tag = tag;
      case (kind)
         KAlu:    e.lat = wb ? 4 : 3;
         KLw:     e.lat = wb ? 5 : 4;
         KSw:     e.lat = 4;
         default: e.lat = 3;
      endcase
      e.lat    += iw + ((kind == KLw || kind == KSw) ? dw : 0);
      e.iren_n  = iw + 1;
      e.mem_n   = (kind == KLw || kind == KSw) ? dw + 1 : 0;
      e.rw_n    = (kind == KAlu || kind == KLw || kind == KJal) ? 1 : 0;
      e.rw_cyc  = (e.rw_n == 1) ? e.lat : 0;
      e.chk_wb  = (e.rw_n == 1);
      e.dst     = dst;
      e.memop   = mo;
      e.pcm     = pm;
      e.chk_alu = chk_alu;
      e.alu     = alu;
      e.chk_ext = chk_ext;
      e.ext     = ext;
      sb.push_back(e);
   endtask

   task automatic run_instr(input logic [31:0] word, input int iw, input int dw, input logic z);
      int         c = 0, iren_n = 0, mem_n = 0, rw_n = 0, rw_cyc = 0, lat = 0;
      bit         done = 1'b0;
      logic [1:0] dst = '0, mo = '0, pm = '0;
      logic       ext = 1'b0, imm = 1'b0;
      logic [31:0] ret = '0;
      aluop_t     alu = ALU_SLL;
      exp_t       e;
      zero = z;
      imemload = word;
      while (!done && c < 40) begin
         @(negedge clk);
         c++;
         ihit = 1'b0;
         dhit = 1'b0;
         if (iren_o) begin
            iren_n++;
            ihit = (iren_n == iw + 1);
         end
         if (dren_o || dwen_o) begin
            mem_n++;
            dhit = (mem_n == dw + 1);
         end
         #1;
         if (regwen_o) begin
            rw_n++;
            rw_cyc = c;
         end
         if (pcwen_o) begin
            done = 1'b1;
            lat  = c;
            dst  = dst_o;
            mo   = memop_o;
            pm   = pcm_o;
            alu  = alu_o;
            ext  = ext_o;
            imm  = imm_o;
            ret  = ret_o;
         end
      end
      e = sb.pop_front();
      chk({e.tag, " commit seen"}, done, 1);
      chk({e.tag, " latency"}, lat, e.lat);
      chk({e.tag, " iREN cycles"}, iren_n, e.iren_n);
      chk({e.tag, " mem cycles"}, mem_n, e.mem_n);
      chk({e.tag, " regWEN pulses"}, rw_n, e.rw_n);
      chk({e.tag, " regWEN cycle"}, rw_cyc, e.rw_cyc);
      chk({e.tag, " pcmode"}, pm, e.pcm);
      chk({e.tag, " retired"}, ret, ret_model);
      if (e.chk_wb) begin
         chk({e.tag, " RdOrRtOr31"}, dst, e.dst);
         chk({e.tag, " memOp"}, mo, e.memop);
      end
      if (e.chk_alu) chk({e.tag, " alu_op"}, alu, e.alu);
      if (e.chk_ext) begin
         chk({e.tag, " extType"}, ext, e.ext);
         chk({e.tag, " immorRt"}, imm, 1);
      end
      ret_model++;
   endtask

   task automatic do_reset(input logic s);
      @(negedge clk);
      sel  = s;
      ihit = 1'b0;
      dhit = 1'b0;
      nrst = 1'b0;
      #1;
      chk("reset instr", instr_o, 0);
      chk("reset iREN", iren_o, 0);
      chk("reset retired", ret_o, 0);
      chk("reset halt/fault", {halt_o, fault_o}, 0);
      @(negedge clk);
      nrst = 1'b1;
      ret_model = 0;
      #1;
      chk("idle enables", {iren_o, dren_o, dwen_o, regwen_o, pcwen_o}, 0);
   endtask

   initial begin
      int k, hp, hi;

      // WB-stage instance: main instruction mix
      do_reset(1'b1);
      push_exp("add", KAlu, 0, 0, 2'd0, 2'd0, 2'd0, 1, ALU_ADD, 0, 1'b0);
      run_instr(32'h00221820, 0, 0, 1'b0);
      push_exp("lw", KLw, 0, 3, 2'd1, 2'd1, 2'd0, 1, ALU_ADD, 1, 1'b1);
      run_instr(32'h8C220004, 0, 3, 1'b0);
      push_exp("sw", KSw, 0, 1, 2'd1, 2'd0, 2'd0, 1, ALU_ADD, 0, 1'b0);
      run_instr(32'hAC220008, 0, 1, 1'b0);
      push_exp("jal", KJal, 0, 0, 2'd2, 2'd2, 2'd2, 0, ALU_ADD, 0, 1'b0);
      run_instr(32'h0C000010, 0, 0, 1'b0);
      push_exp("beq taken", KFlow, 0, 0, 2'd0, 2'd0, 2'd1, 1, ALU_SUB, 0, 1'b0);
      run_instr(32'h10220003, 0, 0, 1'b1);
      push_exp("bne not taken", KFlow, 1, 0, 2'd0, 2'd0, 2'd0, 1, ALU_SUB, 0, 1'b0);
      run_instr(32'h14220003, 1, 0, 1'b1);
      push_exp("ori ihit at limit", KAlu, 3, 0, 2'd1, 2'd0, 2'd0, 1, ALU_OR, 1, 1'b0);
      run_instr(32'h34220FFF, 3, 0, 1'b0);
      push_exp("lui", KAlu, 0, 0, 2'd1, 2'd3, 2'd0, 0, ALU_ADD, 1, 1'b1);
      run_instr(32'h3C011234, 0, 0, 1'b0);
      push_exp("jr", KFlow, 0, 0, 2'd0, 2'd0, 2'd3, 0, ALU_ADD, 0, 1'b0);
      run_instr(32'h03E00008, 0, 0, 1'b0);

      // SW stalled in MEM, then nRST pulsed mid-cycle
      imemload = 32'hAC220008;
      k = 0;
      for (int c = 0; c < 20 && k < 2; c++) begin
         @(negedge clk);
         ihit = iren_o;
         dhit = 1'b0;
         #1;
         if (dwen_o) k++;
      end
      chk("sw stall dWEN", dwen_o, 1);
      chk("sw stall retired", ret_o, ret_model);
      #1 nrst = 1'b0;
      #1;
      chk("async reset dWEN", dwen_o, 0);
      chk("async reset pcWEN", pcwen_o, 0);
      chk("async reset retired", ret_o, 0);
      chk("async reset halt/fault", {halt_o, fault_o}, 0);
      ihit = 1'b0;

      // HALT: sticky, no commit, further ihit ignored
      do_reset(1'b1);
      imemload = 32'hFFFFFFFF;
      @(negedge clk);
      ihit = 1'b1;
      #1 chk("halt fetch iREN", iren_o, 1);
      @(negedge clk);
      ihit = 1'b0;
      #1 chk("halt in decode", halt_o, 0);
      hp = 0;
      hi = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         ihit = 1'b1;
         #1;
         chk("halt sticky", halt_o, 1);
         if (pcwen_o) hp++;
         if (iren_o) hi++;
      end
      chk("halt pcWEN cycles", hp, 0);
      chk("halt iREN cycles", hi, 0);
      chk("halt retired", ret_o, 0);
      chk("halt IR", instr_o, 32'hFFFFFFFF);

      // Watchdog: ihit never arrives
      do_reset(1'b1);
      imemload = 32'h00221820;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ihit = 1'b0;
      end
      #1;
      chk("timeout 4th fetch iREN", iren_o, 1);
      chk("timeout 4th fetch fault", fault_o, 0);
      @(negedge clk);
      #1;
      chk("timeout fault", fault_o, 1);
      chk("timeout iREN off", iren_o, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ihit = 1'b1;
      end
      #1;
      chk("fault sticky", fault_o, 1);
      chk("fault IR not loaded", instr_o, 0);

      // Illegal opcode faults out of DECODE
      do_reset(1'b1);
      imemload = 32'h7C000000;
      @(negedge clk);
      ihit = 1'b1;
      @(negedge clk);
      ihit = 1'b0;
      #1;
      chk("illegal decode fault", fault_o, 0);
      chk("illegal IR", instr_o, 32'h7C000000);
      @(negedge clk);
      #1 chk("illegal fault", fault_o, 1);

      // Instance without a WB stage
      do_reset(1'b0);
      push_exp("nowb add", KAlu, 0, 0, 2'd0, 2'd0, 2'd0, 1, ALU_ADD, 0, 1'b0);
      run_instr(32'h00221820, 0, 0, 1'b0);
      push_exp("nowb lw", KLw, 0, 3, 2'd1, 2'd1, 2'd0, 1, ALU_ADD, 1, 1'b1);
      run_instr(32'h8C220004, 0, 3, 1'b0);
      push_exp("nowb sw", KSw, 0, 0, 2'd1, 2'd0, 2'd0, 1, ALU_ADD, 0, 1'b0);
      run_instr(32'hAC220008, 0, 0, 1'b0);
      push_exp("nowb ori", KAlu, 1, 0, 2'd1, 2'd0, 2'd0, 1, ALU_OR, 1, 1'b0);
      run_instr(32'h34220FFF, 1, 0, 1'b0);
      @(negedge clk);
      ihit = 1'b0;
      dhit = 1'b0;
      #1 chk("nowb final retired", ret_o, ret_model);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
